// File: rtl/folded_modality_fuser_if.sv
// Fold-beat handshake bundle between spatial encoder, fuser and temporal encoder.
// master drives hvin beats and hvout_ready; slave is the fuser.
interface folded_modality_fuser_if #(
  parameter int HV_DIMENSION   = 2000,
  parameter int NUM_FOLDS      = 4,
  parameter int NUM_MODALITIES = 3
);
  localparam int FOLD_WIDTH = HV_DIMENSION / NUM_FOLDS;
  localparam int NUM_FOLDS_WIDTH =
    (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1;
  localparam int MOD_WIDTH =
    (NUM_MODALITIES > 1) ? $clog2(NUM_MODALITIES) : 1;

  logic                       hvin_valid;
  logic                       hvin_ready;
  logic [FOLD_WIDTH-1:0]      hvin;
  logic [NUM_FOLDS_WIDTH-1:0] hvin_fold;
  logic [MOD_WIDTH-1:0]       hvin_modality;
  logic                       hvout_valid;
  logic                       hvout_ready;
  logic [HV_DIMENSION-1:0]    hvout;
  logic                       seq_error;

  modport master (
    output hvin_valid, hvin, hvin_fold, hvin_modality,
    output hvout_ready,
    input  hvin_ready, hvout_valid, hvout, seq_error
  );

  modport slave (
    input  hvin_valid, hvin, hvin_fold, hvin_modality,
    input  hvout_ready,
    output hvin_ready, hvout_valid, hvout, seq_error
  );
endinterface

// File: rtl/folded_modality_fuser.sv
// Folded majority-vote fuser: bundles NUM_MODALITIES fold beats per fold.
// Define FUSER_SEQ_CHECK_EN to check beat tags and raise sticky seq_error.
module folded_modality_fuser #(
  parameter int HV_DIMENSION    = 2000,
  parameter int NUM_FOLDS       = 4,
  parameter int NUM_MODALITIES  = 3,
  parameter int FOLD_WIDTH      = HV_DIMENSION / NUM_FOLDS,
  parameter int NUM_FOLDS_WIDTH =
    (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  parameter int MOD_WIDTH       =
    (NUM_MODALITIES > 1) ? $clog2(NUM_MODALITIES) : 1
) (
  input logic                    clk,
  input logic                    rst,
  folded_modality_fuser_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_MODALITIES + 1);
  localparam bit EVEN  = (NUM_MODALITIES % 2) == 0;
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(NUM_MODALITIES / 2);
  localparam logic [MOD_WIDTH-1:0] LAST_MOD =
    MOD_WIDTH'(NUM_MODALITIES - 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD =
    NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  typedef enum logic {
    ACCUM,
    OUTPUT
  } state_t;

  state_t                     state;
  logic [NUM_FOLDS_WIDTH-1:0] fold_cnt;
  logic [MOD_WIDTH-1:0]       mod_cnt;
  logic [CNT_W-1:0]           cnt [FOLD_WIDTH];
  logic [FOLD_WIDTH-1:0]      mod0_q;
  logic [FOLD_WIDTH-1:0]      fused;
  logic [CNT_W-1:0]           sum_v;
  logic                       ready_q;
  logic                       valid_q;
  logic [HV_DIMENSION-1:0]    hvout_q;

  logic xfer;
  logic seq_ok;
  logic accept;
  logic last_mod;
  logic last_fold;

  assign xfer      = bus.hvin_valid && ready_q;
  assign accept    = xfer && seq_ok;
  assign last_mod  = mod_cnt == LAST_MOD;
  assign last_fold = fold_cnt == LAST_FOLD;

`ifdef FUSER_SEQ_CHECK_EN
  logic seq_err_q;

  assign seq_ok = (bus.hvin_fold == fold_cnt) &&
                  (bus.hvin_modality == mod_cnt);

  // Sticky: only reset clears a sequencing fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err_q <= 1'b0;
    end else if (xfer && !seq_ok) begin
      seq_err_q <= 1'b1;
    end
  end

  assign bus.seq_error = seq_err_q;
`else
  logic unused_tags;

  assign seq_ok        = 1'b1;
  assign unused_tags   = ^{bus.hvin_fold, bus.hvin_modality};
  assign bus.seq_error = 1'b0;
`endif

  // Last beat's bit is added on the fly; ties fall back to modality 0.
  always_comb begin
    fused = '0;
    sum_v = '0;
    for (int i = 0; i < FOLD_WIDTH; i++) begin
      sum_v = cnt[i] + CNT_W'(bus.hvin[i]);
      if (EVEN && sum_v == HALF) begin
        fused[i] = mod0_q[i];
      end else begin
        fused[i] = sum_v > HALF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FOLD_WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < FOLD_WIDTH; i++) begin
        cnt[i] <= last_mod ? '0 : cnt[i] + CNT_W'(bus.hvin[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      fold_cnt <= '0;
      mod_cnt  <= '0;
      mod0_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      hvout_q  <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (mod_cnt == '0) begin
              mod0_q <= bus.hvin;
            end
            if (last_mod) begin
              mod_cnt <= '0;
              for (int f = 0; f < NUM_FOLDS; f++) begin
                if (fold_cnt == NUM_FOLDS_WIDTH'(f)) begin
                  hvout_q[f*FOLD_WIDTH +: FOLD_WIDTH] <= fused;
                end
              end
              if (last_fold) begin
                fold_cnt <= '0;
                state    <= OUTPUT;
                ready_q  <= 1'b0;
                valid_q  <= 1'b1;
              end else begin
                fold_cnt <= fold_cnt + 1'b1;
              end
            end else begin
              mod_cnt <= mod_cnt + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.hvout_ready) begin
            state   <= ACCUM;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.hvin_ready  = ready_q;
  assign bus.hvout_valid = valid_q;
  assign bus.hvout       = hvout_q;

endmodule
